// File: rtl/parser_rule_cfg.sv
// parser_rule_cfg
// Assembles multi-beat rule images from a 32-bit valid/ready config stream
// and commits them to one parser stage's type-lookup rule table through a
// one-cycle write strobe. One instance per parser stage.
//
// Ports
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_cfg_valid/data/last   config beat stream (header + optional payload)
//   o_cfg_ready             beat accepted when valid & ready
//   o_rule_wren             one-cycle per-entry write strobe (all ones = invalidate all)
//   o_typeRule_*            rule fields written with the strobe; held until next commit
//   o_busy                  a command is in progress
//   o_wr_cnt / o_err_cnt    committed / rejected command counts, saturating
//
// Header beat: [31:28] opcode (1 WRITE, 2 INVALIDATE, 3 INVALIDATE_ALL),
// [27:20] rule index. WRITE carries NBEAT payload beats, image LSB first:
// {metaShift, headShift, keyOffset, typeOffset, typeMask, typeData, valid}.
//
// state     | meaning
// S_HDR     | waiting for a command header
// S_PAYLOAD | collecting WRITE payload beats
// S_COMMIT  | write strobe on the table port, input stalled for one cycle
// S_DRAIN   | rejected command, swallowing beats up to its last

module parser_rule_cfg #(
    parameter int RULE_NUM          = 8,
    parameter int TYPE_NUM          = 4,
    parameter int TYPE_WIDTH        = 16,
    parameter int TYPE_OFFSET_WIDTH = 8,
    parameter int KEY_FILED_NUM     = 8,
    parameter int KEY_OFFSET_WIDTH  = 6,
    parameter int HEAD_SHIFT_WIDTH  = 6,
    parameter int META_SHIFT_WIDTH  = 6
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst_n,
    input  logic                                          i_cfg_valid,
    input  logic [31:0]                                   i_cfg_data,
    input  logic                                          i_cfg_last,
    output logic                                          o_cfg_ready,
    output logic [RULE_NUM-1:0]                           o_rule_wren,
    output logic                                          o_typeRule_valid,
    output logic [TYPE_NUM*TYPE_WIDTH-1:0]                o_typeRule_typeData,
    output logic [TYPE_NUM*TYPE_WIDTH-1:0]                o_typeRule_typeMask,
    output logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]         o_typeRule_typeOffset,
    output logic [KEY_FILED_NUM*(KEY_OFFSET_WIDTH+1)-1:0] o_typeRule_keyOffset,
    output logic [HEAD_SHIFT_WIDTH-1:0]                   o_typeRule_headShift,
    output logic [META_SHIFT_WIDTH-1:0]                   o_typeRule_metaShift,
    output logic                                          o_busy,
    output logic [15:0]                                   o_wr_cnt,
    output logic [15:0]                                   o_err_cnt
);

    localparam int TD_W = TYPE_NUM * TYPE_WIDTH;
    localparam int TO_W = TYPE_NUM * TYPE_OFFSET_WIDTH;
    localparam int KO_W = KEY_FILED_NUM * (KEY_OFFSET_WIDTH + 1);

    localparam int RULE_BITS = 1 + 2 * TD_W + TO_W + KO_W + HEAD_SHIFT_WIDTH + META_SHIFT_WIDTH;
    localparam int NBEAT     = (RULE_BITS + 31) / 32;
    localparam int CNT_W     = $clog2(NBEAT + 1);
    localparam int IMG_BITS  = (NBEAT - 1) * 32;

    localparam int OFF_TD = 1;
    localparam int OFF_TM = OFF_TD + TD_W;
    localparam int OFF_TO = OFF_TM + TD_W;
    localparam int OFF_KO = OFF_TO + TO_W;
    localparam int OFF_HS = OFF_KO + KO_W;
    localparam int OFF_MS = OFF_HS + HEAD_SHIFT_WIDTH;

    localparam logic [3:0] OP_WRITE   = 4'h1;
    localparam logic [3:0] OP_INV     = 4'h2;
    localparam logic [3:0] OP_INV_ALL = 4'h3;

    localparam logic [RULE_NUM-1:0] WREN_ONE = RULE_NUM'(1);

    typedef enum logic [1:0] {
        S_HDR,
        S_PAYLOAD,
        S_COMMIT,
        S_DRAIN
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     beat_cnt;
    logic [7:0]           idx_q;
    // Holds beats 0..NBEAT-2; the final beat is taken straight off the bus at commit.
    logic [IMG_BITS-1:0]  img;
    logic [RULE_BITS-1:0] full;

    logic       accept;
    logic [3:0] hdr_op;
    logic [7:0] hdr_idx;
    logic       idx_ok;
    logic       final_beat;

    assign accept     = i_cfg_valid & o_cfg_ready;
    assign hdr_op     = i_cfg_data[31:28];
    assign hdr_idx    = i_cfg_data[27:20];
    assign idx_ok     = {1'b0, hdr_idx} < 9'(RULE_NUM);
    assign final_beat = (beat_cnt == CNT_W'(NBEAT - 1));
    // Padding bits above RULE_BITS in the last beat are dropped here.
    assign full       = RULE_BITS'({i_cfg_data, img});

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // o_cfg_ready defaults to 1 and is cleared only on entry to S_COMMIT,
    // so it always reflects the state being entered.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state                 <= S_HDR;
            beat_cnt              <= '0;
            idx_q                 <= '0;
            img                   <= '0;
            o_cfg_ready           <= 1'b0;
            o_busy                <= 1'b0;
            o_rule_wren           <= '0;
            o_typeRule_valid      <= 1'b0;
            o_typeRule_typeData   <= '0;
            o_typeRule_typeMask   <= '0;
            o_typeRule_typeOffset <= '0;
            o_typeRule_keyOffset  <= '0;
            o_typeRule_headShift  <= '0;
            o_typeRule_metaShift  <= '0;
            o_wr_cnt              <= '0;
            o_err_cnt             <= '0;
        end else begin
            o_rule_wren <= '0;
            o_cfg_ready <= 1'b1;
            case (state)
                S_HDR: begin
                    if (accept) begin
                        beat_cnt <= '0;
                        idx_q    <= hdr_idx;
                        if (hdr_op == OP_WRITE && idx_ok && !i_cfg_last) begin
                            state  <= S_PAYLOAD;
                            o_busy <= 1'b1;
                        end else if (i_cfg_last &&
                                     ((hdr_op == OP_INV && idx_ok) || hdr_op == OP_INV_ALL)) begin
                            state                 <= S_COMMIT;
                            o_busy                <= 1'b1;
                            o_cfg_ready           <= 1'b0;
                            o_rule_wren           <= (hdr_op == OP_INV_ALL) ? '1 : (WREN_ONE << hdr_idx);
                            o_typeRule_valid      <= 1'b0;
                            o_typeRule_typeData   <= '0;
                            o_typeRule_typeMask   <= '0;
                            o_typeRule_typeOffset <= '0;
                            o_typeRule_keyOffset  <= '0;
                            o_typeRule_headShift  <= '0;
                            o_typeRule_metaShift  <= '0;
                        end else begin
                            o_err_cnt <= sat_inc(o_err_cnt);
                            if (!i_cfg_last) begin
                                state  <= S_DRAIN;
                                o_busy <= 1'b1;
                            end
                        end
                    end
                end

                S_PAYLOAD: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        // A discarded partial image needs no clearing: every
                        // committed WRITE overwrites all of img first.
                        for (int k = 0; k < NBEAT - 1; k++) begin
                            if (beat_cnt == CNT_W'(k)) begin
                                img[k*32 +: 32] <= i_cfg_data;
                            end
                        end
                        if (final_beat) begin
                            if (i_cfg_last) begin
                                state                 <= S_COMMIT;
                                o_cfg_ready           <= 1'b0;
                                o_rule_wren           <= WREN_ONE << idx_q;
                                o_typeRule_valid      <= full[0];
                                o_typeRule_typeData   <= full[OFF_TD +: TD_W];
                                o_typeRule_typeMask   <= full[OFF_TM +: TD_W];
                                o_typeRule_typeOffset <= full[OFF_TO +: TO_W];
                                o_typeRule_keyOffset  <= full[OFF_KO +: KO_W];
                                o_typeRule_headShift  <= full[OFF_HS +: HEAD_SHIFT_WIDTH];
                                o_typeRule_metaShift  <= full[OFF_MS +: META_SHIFT_WIDTH];
                            end else begin
                                state     <= S_DRAIN;
                                o_err_cnt <= sat_inc(o_err_cnt);
                            end
                        end else if (i_cfg_last) begin
                            state     <= S_HDR;
                            o_busy    <= 1'b0;
                            o_err_cnt <= sat_inc(o_err_cnt);
                        end
                    end
                end

                S_COMMIT: begin
                    state    <= S_HDR;
                    o_busy   <= 1'b0;
                    o_wr_cnt <= sat_inc(o_wr_cnt);
                end

                S_DRAIN: begin
                    if (accept && i_cfg_last) begin
                        state  <= S_HDR;
                        o_busy <= 1'b0;
                    end
                end

                default: begin
                    state  <= S_HDR;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
